sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port (req / addr_ok / data_ok) between the instruction-fetch requester and the MEM-stage data requester.
- Arbitrates address phases. Data has priority, with a starvation guard for fetch.
- Tracks accepted transactions in an in-order ID FIFO and routes each data_ok/rdata back to its owner.
- Supports dropping responses of cancelled fetches after a pipeline flush. Sits between the core's two request ports and the memory bridge.

Parameters:
DEPTH, 4, max outstanding accepted transactions (power of 2, >=2)
STARVE_LIMIT, 4, consecutive data grants while inst_req pending before fetch is forced one grant

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
inst_req  in  1  fetch request valid
inst_wr  in  1  fetch write (normally 0)
inst_size  in  2  fetch size
inst_wstrb  in  4  fetch byte strobes
inst_addr  in  32  fetch address
inst_wdata  in  32  fetch write data
inst_addr_ok  out  1  fetch request accepted
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch read data
data_req  in  1  MEM-stage request valid
data_wr  in  1  MEM-stage write
data_size  in  2  MEM-stage size
data_wstrb  in  4  MEM-stage byte strobes
data_addr  in  32  MEM-stage address
data_wdata  in  32  MEM-stage write data
data_addr_ok  out  1  MEM-stage request accepted
data_data_ok  out  1  MEM-stage response valid
data_rdata  out  32  MEM-stage read data
inst_cancel  in  1  pulse: drop responses of all accepted fetches
mem_req  out  1  shared port request
mem_wr  out  1  shared write
mem_size  out  2  shared size
mem_wstrb  out  4  shared strobes
mem_addr  out  32  shared address
mem_wdata  out  32  shared write data
mem_addr_ok  in  1  shared accept
mem_data_ok  in  1  shared response valid
mem_rdata  in  32  shared read data

Behaviour:
- Reset (rst high at posedge): lock, ID FIFO, count and starvation counter cleared. Output control signals (mem_req, all *_addr_ok, all *_data_ok) are 0 for as long as rst is high. Rdata outputs pass mem_rdata through.
- Handshake: a requester holds req and payload stable until it sees addr_ok. A transfer occurs on the cycle where req and addr_ok are both high.
- Arbitration, combinational, when unlocked:
  - sel = INST if inst_req & (~data_req | starve_cnt==STARVE_LIMIT); otherwise DATA if data_req.
  - mem_req = (inst_req | data_req) & (count != DEPTH).
  - mem_* payload muxed from sel.
- Lock: if mem_req & ~mem_addr_ok, register lock=1 and lock_id=sel. While locked, sel=lock_id regardless of priority, so the payload on the port cannot change mid-handshake. Lock clears on mem_addr_ok.
- Accept routing: inst_addr_ok = mem_req & mem_addr_ok & sel==INST. data_addr_ok is analogous. Never both high.
- Starvation counter:
  - Increments on an accepted DATA grant while inst_req is high.
  - Resets to 0 on an accepted INST grant, or when inst_req is low.
  - Saturates at STARVE_LIMIT.
- ID FIFO, DEPTH entries of {id, drop}:
  - Push on accept.
  - Pop on mem_data_ok when count != 0.
  - Push and pop in the same cycle leave count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Full (count==DEPTH): mem_req forced 0, no addr_ok to either requester; the lock is held.
- Response routing (same cycle as mem_data_ok):
  - inst_data_ok = mem_data_ok & head.id==INST & ~head.drop.
  - data_data_ok = mem_data_ok & head.id==DATA.
  - Dropped entries are popped silently.
  - mem_data_ok with count==0 is ignored: no pop, no *_data_ok.
- inst_cancel:
  - Sets drop on every valid FIFO entry with id INST, including an INST entry pushed in the same cycle.
  - If the head INST entry pops in the same cycle, its inst_data_ok is suppressed.
  - Does not affect DATA entries, the lock, or an unaccepted pending request.
- Latency: addr_ok is combinational from mem_addr_ok (0 cycles added). data_ok is combinational from mem_data_ok.

Test Plan:
- Both idle after rst -> mem_req=0, count=0. Single data read 0x1000, mem_addr_ok same cycle, data_ok 2 cycles later with rdata=0xDEADBEEF -> data_addr_ok=1 at cycle 0, data_data_ok=1 with 0xDEADBEEF, inst_data_ok=0.
- inst_req and data_req both high, mem_addr_ok every cycle, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D…; inst_addr_ok in cycle 4.
- inst_req alone with mem_addr_ok low for 3 cycles, data_req rising in cycle 1 -> port stays on inst_addr through cycle 3; inst accepted first, data accepted next.
- 4 accepted reads, no data_ok -> count=4, mem_req=0 despite data_req=1. One mem_data_ok -> mem_req=1 the next cycle.
- Accept I,D,I; pulse inst_cancel; return 3 data_ok -> only data_data_ok pulses (2nd response); inst_data_ok stays 0; count returns to 0.
- rst asserted with 2 outstanding and lock set -> next cycle count=0, lock=0, mem_req=0; a subsequent stray mem_data_ok produces no *_data_ok.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and MEM-stage data requests,
// tracking accepted transactions in order so each response returns to its owner.
module sram_req_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        inst_cancel,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t      lock_state, lock_next;
    src_t             lock_id, lock_id_next;
    src_t             sel;

    logic [SC_W-1:0]  starve_cnt;
    logic             starved;

    logic [DEPTH-1:0] fifo_is_data, fifo_is_data_next;
    logic [DEPTH-1:0] fifo_drop, fifo_drop_next;
    logic [DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] offs;

    logic             full;
    logic             accept;
    logic             push, pop;
    logic             head_is_data, head_drop;

    assign full    = (count == CNT_W'(DEPTH));
    assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));

    // A locked port keeps its owner until accepted so the payload never changes mid-handshake.
    always_comb begin
        sel = SRC_DATA;
        if (lock_state == LOCKED) begin
            sel = lock_id;
        end else if (inst_req && (!data_req || starved)) begin
            sel = SRC_INST;
        end
    end

    assign mem_req      = !rst && (inst_req || data_req) && !full;
    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && (sel == SRC_INST);
    assign data_addr_ok = accept && (sel == SRC_DATA);

    always_comb begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        if (sel == SRC_INST) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    always_comb begin
        lock_next    = lock_state;
        lock_id_next = lock_id;
        if (mem_req) begin
            if (mem_addr_ok) begin
                lock_next = UNLOCKED;
            end else begin
                lock_next    = LOCKED;
                lock_id_next = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= UNLOCKED;
            lock_id    <= SRC_INST;
        end else begin
            lock_state <= lock_next;
            lock_id    <= lock_id_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!inst_req || inst_addr_ok) begin
            starve_cnt <= '0;
        end else if (data_addr_ok && !starved) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assign push         = accept;
    assign pop          = !rst && mem_data_ok && (count != '0);
    assign head_is_data = fifo_is_data[rd_ptr];
    assign head_drop    = fifo_drop[rd_ptr];

    assign inst_data_ok = pop && !head_is_data && !head_drop && !inst_cancel;
    assign data_data_ok = pop && head_is_data;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Entry i is live when its distance from the head (mod DEPTH) is below count.
    always_comb begin
        entry_valid = '0;
        offs        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs           = PTR_W'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offs} < count);
        end
    end

    always_comb begin
        fifo_is_data_next = fifo_is_data;
        fifo_drop_next    = fifo_drop;
        if (inst_cancel) begin
            fifo_drop_next = fifo_drop | (entry_valid & ~fifo_is_data);
        end
        if (push) begin
            fifo_is_data_next[wr_ptr] = (sel == SRC_DATA);
            fifo_drop_next[wr_ptr]    = inst_cancel && (sel == SRC_INST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_is_data <= '0;
            fifo_drop    <= '0;
        end else begin
            fifo_is_data <= fifo_is_data_next;
            fifo_drop    <= fifo_drop_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    a_single_accept: assert property (@(posedge clk) disable iff (rst)
        !(inst_addr_ok && data_addr_ok));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: reset, priority/starvation, lock, full FIFO,
// fetch cancel and reset-while-busy, with hand-computed expectations.
module tb_sram_req_arbiter;

    localparam logic [31:0] IA = 32'h0000_2000;
    localparam logic [31:0] DA = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        inst_cancel;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passes = 0;

    sram_req_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .inst_cancel(inst_cancel),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after a rising edge; the short settle leaves checks mid-cycle.
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwr, input logic [31:0] daddr,
                                 input logic aok, input logic dok, input logic [31:0] rdata,
                                 input logic cancel);
        inst_req    = ireq;
        inst_addr   = iaddr;
        data_req    = dreq;
        data_wr     = dwr;
        data_addr   = daddr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
        inst_cancel = cancel;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wstrb = 4'hF;
        inst_wdata = 32'h0;
        data_size  = 2'd2;
        data_wstrb = 4'hF;
        data_wdata = 32'hCAFE_0000;

        // Reset holds every control output low even with all inputs active
        rst = 1'b1;
        applyStimulus(1'b1, IA, 1'b1, 1'b0, DA, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        checkOutput("rst_mem_req",   32'(mem_req),      32'd0);
        checkOutput("rst_inst_aok",  32'(inst_addr_ok), 32'd0);
        checkOutput("rst_data_aok",  32'(data_addr_ok), 32'd0);
        checkOutput("rst_inst_dok",  32'(inst_data_ok), 32'd0);
        checkOutput("rst_data_dok",  32'(data_data_ok), 32'd0);
        checkOutput("rst_rdata_pass", data_rdata,       32'h1234_5678);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("idle_mem_req", 32'(mem_req), 32'd0);

        // Single data read
        applyStimulus(1'b0, IA, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_mem_req",  32'(mem_req),      32'd1);
        checkOutput("t1_mem_addr", mem_addr,          32'h0000_1000);
        checkOutput("t1_data_aok", 32'(data_addr_ok), 32'd1);
        checkOutput("t1_inst_aok", 32'(inst_addr_ok), 32'd0);
        tick();
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("t1_data_dok",   32'(data_data_ok), 32'd1);
        checkOutput("t1_data_rdata", data_rdata,        32'hDEAD_BEEF);
        checkOutput("t1_inst_dok",   32'(inst_data_ok), 32'd0);
        tick();

        // Both requesting: D,D,D,D,I,D with one response popped per cycle from cycle 1
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, IA, 1'b1, 1'b0, DA, 1'b1, (c > 0), 32'h100 + 32'(c), 1'b0);
            checkOutput($sformatf("t2_inst_aok_c%0d", c), 32'(inst_addr_ok), 32'(c == 4));
            checkOutput($sformatf("t2_data_aok_c%0d", c), 32'(data_addr_ok), 32'(c != 4));
            checkOutput($sformatf("t2_mem_addr_c%0d", c), mem_addr, (c == 4) ? IA : DA);
            checkOutput($sformatf("t2_inst_dok_c%0d", c), 32'(inst_data_ok), 32'(c == 5));
            checkOutput($sformatf("t2_data_dok_c%0d", c), 32'(data_data_ok),
                        32'(c >= 1 && c <= 4));
            tick();
        end
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("t2_last_data_dok", 32'(data_data_ok), 32'd1);
        tick();

        // Lock: fetch stalled by the port keeps ownership after data rises
        applyStimulus(1'b1, IA, 1'b0, 1'b0, DA, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_c0_mem_req",  32'(mem_req),      32'd1);
        checkOutput("t3_c0_mem_addr", mem_addr,          IA);
        checkOutput("t3_c0_inst_aok", 32'(inst_addr_ok), 32'd0);
        tick();
        for (int c = 1; c < 3; c++) begin
            applyStimulus(1'b1, IA, 1'b1, 1'b0, DA, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("t3_c%0d_mem_addr", c), mem_addr, IA);
            tick();
        end
        applyStimulus(1'b1, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_c3_mem_addr", mem_addr,          IA);
        checkOutput("t3_c3_inst_aok", 32'(inst_addr_ok), 32'd1);
        checkOutput("t3_c3_data_aok", 32'(data_addr_ok), 32'd0);
        tick();
        applyStimulus(1'b0, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_c4_data_aok", 32'(data_addr_ok), 32'd1);
        checkOutput("t3_c4_mem_addr", mem_addr,          DA);
        tick();
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
        checkOutput("t3_inst_dok",   32'(inst_data_ok), 32'd1);
        checkOutput("t3_inst_rdata", inst_rdata,        32'h1111_1111);
        checkOutput("t3_data_dok0",  32'(data_data_ok), 32'd0);
        tick();
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
        checkOutput("t3_data_dok",  32'(data_data_ok), 32'd1);
        checkOutput("t3_inst_dok0", 32'(inst_data_ok), 32'd0);
        tick();

        // Full FIFO blocks the port until a response frees a slot
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, IA, 1'b1, 1'b0, DA + 32'(4 * c), 1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("t4_fill_aok_c%0d", c), 32'(data_addr_ok), 32'd1);
            tick();
        end
        applyStimulus(1'b0, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_full_mem_req",  32'(mem_req),      32'd0);
        checkOutput("t4_full_data_aok", 32'(data_addr_ok), 32'd0);
        tick();
        applyStimulus(1'b0, IA, 1'b1, 1'b0, DA, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("t4_pop_mem_req",  32'(mem_req),      32'd0);
        checkOutput("t4_pop_data_dok", 32'(data_data_ok), 32'd1);
        tick();
        applyStimulus(1'b0, IA, 1'b1, 1'b0, DA, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_freed_mem_req", 32'(mem_req), 32'd1);
        tick();
        applyStimulus(1'b0, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_refill_aok", 32'(data_addr_ok), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h0, 1'b0);
            checkOutput($sformatf("t4_drain_dok_%0d", k), 32'(data_data_ok), 32'd1);
            tick();
        end
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("t4_stray_data_dok", 32'(data_data_ok), 32'd0);
        checkOutput("t4_stray_inst_dok", 32'(inst_data_ok), 32'd0);
        tick();

        // Cancel drops both outstanding fetch responses but keeps the data one
        applyStimulus(1'b1, IA, 1'b0, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_i0_aok", 32'(inst_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b0, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_d1_aok", 32'(data_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b1, IA + 32'd4, 1'b0, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_i2_aok", 32'(inst_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'hA0 + 32'(k), 1'b0);
            checkOutput($sformatf("t5_inst_dok_%0d", k), 32'(inst_data_ok), 32'd0);
            checkOutput($sformatf("t5_data_dok_%0d", k), 32'(data_data_ok), 32'(k == 1));
            tick();
        end
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("t5_empty_data_dok", 32'(data_data_ok), 32'd0);
        tick();

        // Reset with two outstanding and the port locked on fetch
        applyStimulus(1'b0, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_d_aok", 32'(data_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b1, IA, 1'b0, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_i_aok", 32'(inst_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b1, IA, 1'b0, 1'b0, DA, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_stall_mem_req", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_rst_mem_req",  32'(mem_req),      32'd0);
        checkOutput("t6_rst_inst_aok", 32'(inst_addr_ok), 32'd0);
        checkOutput("t6_rst_data_aok", 32'(data_addr_ok), 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("t6_stray_data_dok", 32'(data_data_ok), 32'd0);
        checkOutput("t6_stray_inst_dok", 32'(inst_data_ok), 32'd0);
        checkOutput("t6_post_mem_req",   32'(mem_req),      32'd0);
        tick();
        applyStimulus(1'b1, IA, 1'b1, 1'b0, DA, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_unlock_data_aok", 32'(data_addr_ok), 32'd1);
        checkOutput("t6_unlock_inst_aok", 32'(inst_addr_ok), 32'd0);
        checkOutput("t6_unlock_mem_addr", mem_addr,          DA);
        tick();
        applyStimulus(1'b0, IA, 1'b0, 1'b0, DA, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("t6_final_data_dok", 32'(data_data_ok), 32'd1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
